// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: command, datapath handshake and OFM write signals of layer_sequencer
interface layer_sequencer_if #(
  parameter int CNT_WIDTH = 16,
  parameter int LD_WIDTH  = 8
);
  logic                 start;
  logic [1:0]           mode;
  logic [CNT_WIDTH-1:0] out_count;
  logic [LD_WIDTH-1:0]  load_cycles;
  logic                 load_en;
  logic [LD_WIDTH-1:0]  load_idx;
  logic                 pe_start;
  logic                 pe_done;
  logic                 act_done;
  logic                 pool_start;
  logic                 pool_done;
  logic                 wr_en;
  logic [CNT_WIDTH-1:0] wr_addr;
  logic                 busy;
  logic                 done;
  logic                 err;
  modport master (
    input  start, mode, out_count, load_cycles, pe_done, act_done, pool_done,
    output load_en, load_idx, pe_start, pool_start, wr_en, wr_addr, busy, done, err
  );
  modport slave (
    output start, mode, out_count, load_cycles, pe_done, act_done, pool_done,
    input  load_en, load_idx, pe_start, pool_start, wr_en, wr_addr, busy, done, err
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: layer-level control FSM (load -> PE -> activation -> OFM write per output element).
// MITO_POOL_EN adds POOL mode with the POOL_GO/WAIT_POOL states; without it POOL is rejected.
module layer_sequencer #(
  parameter int         CNT_WIDTH = 16,
  parameter int         LD_WIDTH  = 8,
  parameter int         TIMEOUT   = 1024,
  parameter logic [1:0] CONVOL    = 2'b01,
  parameter logic [1:0] FULLY     = 2'b10,
  parameter logic [1:0] POOL      = 2'b11
) (
  input logic               clk,
  input logic               rst_n,
  layer_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 2);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_PE_GO, S_WAIT_PE, S_WAIT_ACT,
`ifdef MITO_POOL_EN
    S_POOL_GO, S_WAIT_POOL,
`endif
    S_WRITE, S_DONE
  } state_t;
  state_t               r_state, w_next, w_go, w_first;
  logic [CNT_WIDTH-1:0] r_cnt, r_idx;
  logic [LD_WIDTH-1:0]  r_ldc, r_ld, w_ldc;
  logic [WD_W-1:0]      r_wd;
  logic                 w_mode_ok, w_wd_exp, w_err;
`ifdef MITO_POOL_EN
  logic [1:0] r_mode, w_mode;
  assign w_mode    = (r_state == S_IDLE) ? bus.mode : r_mode;
  assign w_mode_ok = bus.mode == CONVOL || bus.mode == FULLY || bus.mode == POOL;
  assign w_go      = (w_mode == POOL) ? S_POOL_GO : S_PE_GO;
  // layer mode is only needed to choose between the PE and pooling paths
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mode <= 2'b00;
    else if (r_state == S_IDLE && bus.start && w_mode_ok) r_mode <= bus.mode;
`else
  assign w_mode_ok = bus.mode == CONVOL || bus.mode == FULLY;
  assign w_go      = S_PE_GO;
`endif
  assign w_ldc    = (r_state == S_IDLE) ? bus.load_cycles : r_ldc;
  assign w_first  = (w_ldc == '0) ? w_go : S_LOAD;
  assign w_wd_exp = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT - 1));
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state and error pulse; awaited pulses win over a same-cycle watchdog expiry
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        if (!w_mode_ok) w_err = 1'b1;
        else w_next = (bus.out_count == '0) ? S_DONE : w_first;
      end
      S_LOAD:  if (r_ld == r_ldc - LD_WIDTH'(1)) w_next = w_go;
      S_PE_GO: w_next = S_WAIT_PE;
      S_WAIT_PE: begin
        if (bus.pe_done) w_next = S_WAIT_ACT;
        else if (w_wd_exp) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_WAIT_ACT: begin
        if (bus.act_done) w_next = S_WRITE;
        else if (w_wd_exp) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
`ifdef MITO_POOL_EN
      S_POOL_GO: w_next = S_WAIT_POOL;
      S_WAIT_POOL: begin
        if (bus.pool_done) w_next = S_WRITE;
        else if (w_wd_exp) begin
          w_err  = 1'b1;
          w_next = S_IDLE;
        end
      end
`endif
      S_WRITE: w_next = (r_idx == r_cnt - CNT_WIDTH'(1)) ? S_DONE : w_first;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // latch the layer size and window length when a command is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_ldc <= '0;
    end else if (r_state == S_IDLE && bus.start && w_mode_ok) begin
      r_cnt <= bus.out_count;
      r_ldc <= bus.load_cycles;
    end
  // output index, word-in-window and watchdog counters; the latter two restart on every state change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_ld  <= '0;
      r_wd  <= '0;
    end else begin
      r_idx <= (r_state == S_IDLE) ? '0 :
               (r_state == S_WRITE && w_next != S_DONE) ? r_idx + CNT_WIDTH'(1) : r_idx;
      r_ld  <= (r_state == S_LOAD && w_next == S_LOAD) ? r_ld + LD_WIDTH'(1) : '0;
      r_wd  <= (w_next == r_state) ? r_wd + WD_W'(1) : '0;
    end
  assign bus.load_en  = r_state == S_LOAD;
  assign bus.load_idx = r_ld;
  assign bus.pe_start = r_state == S_PE_GO;
`ifdef MITO_POOL_EN
  assign bus.pool_start = r_state == S_POOL_GO;
`else
  assign bus.pool_start = 1'b0;
`endif
  assign bus.wr_en   = r_state == S_WRITE;
  assign bus.wr_addr = r_idx;
  assign bus.busy    = r_state != S_IDLE;
  assign bus.done    = r_state == S_DONE;
  assign bus.err     = w_err;
endmodule
